// File: rtl/snn_phase_ctrl.sv
// snn_phase_ctrl: phase sequencer for the spiking-network core.
// Runs synapse init, learning (LERN/STDP + rest tail) and inference
// (INFR + rest tail) across N_GRP neuron groups, gated by a latched
// per-group participation mask, with abort and step-count export.
module snn_phase_ctrl #(
  parameter int unsigned N_GRP       = 8,
  parameter int unsigned TS_W        = 11,
  parameter int unsigned LEARN_STEPS = 800,
  parameter int unsigned TOTAL_STEPS = 1300,
  parameter int unsigned SUB_LOG2    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_init,
  input  logic             i_lern,
  input  logic             i_infr,
  input  logic             i_abort,
  input  logic [N_GRP-1:0] i_grp_mask,
  input  logic [N_GRP-1:0] i_syn_done,
  input  logic [N_GRP-1:0] i_inh_valid,
  input  logic [N_GRP-1:0] i_stdp_done,
  output logic             o_run,
  output logic             o_init,
  output logic             o_rest_run,
  output logic             o_stdp_run,
  output logic             o_cnt_en,
  output logic             o_cnt_clr,
  output logic             o_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [2:0]       o_state,
  output logic [TS_W-1:0]  o_time_step
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_LERN = 3'd2,
    S_LRST = 3'd3,
    S_INFR = 3'd4,
    S_IRST = 3'd5,
    S_STDP = 3'd6,
    S_DONE = 3'd7
  } state_t;

  localparam logic [TS_W-1:0] LEARN_TS = TS_W'(LEARN_STEPS);
  localparam logic [TS_W-1:0] TOTAL_TS = TS_W'(TOTAL_STEPS);

  state_t           cs, ns;
  logic [TS_W-1:0]  ts, ts_nxt, ts_inc;
  logic             req, req_nxt, rearm;
  logic [N_GRP-1:0] mask_q, mask_nxt;
  logic             aborted_q, aborted_nxt;
  logic             all_syn, all_inh, all_stdp;
  logic             busy;

  // Group completion: masked-out groups count as already complete
  always_comb begin
    all_syn  = &(i_syn_done  | ~mask_q);
    all_inh  = &(i_inh_valid | ~mask_q);
    all_stdp = &(i_stdp_done | ~mask_q);
  end

  // State, step counter, request flag, mask and abort status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs        <= S_IDLE;
      ts        <= '0;
      req       <= 1'b0;
      mask_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      cs        <= ns;
      ts        <= ts_nxt;
      req       <= req_nxt;
      mask_q    <= mask_nxt;
      aborted_q <= aborted_nxt;
    end
  end

  // Next-state, step update and request re-arm; completion flags are
  // ignored while req is high so a stale valid from the previous step
  // cannot complete the freshly started one.
  always_comb begin
    ns          = cs;
    ts_nxt      = ts;
    mask_nxt    = mask_q;
    aborted_nxt = aborted_q;
    rearm       = 1'b0;
    ts_inc      = ts + 1'b1;
    case (cs)
      S_IDLE: begin
        if ((i_init || i_lern || i_infr) && (i_grp_mask != '0)) begin
          mask_nxt    = i_grp_mask;
          ts_nxt      = '0;
          aborted_nxt = 1'b0;
          if (i_init)      ns = S_INIT;
          else if (i_lern) ns = S_LERN;
          else             ns = S_INFR;
        end
      end
      S_INIT: if (!req && all_syn) ns = S_DONE;
      S_LERN, S_LRST: if (!req && all_inh) ns = S_STDP;
      S_STDP: begin
        if (!req && all_stdp) begin
          ts_nxt = ts_inc;
          if (ts_inc == TOTAL_TS)     ns = S_DONE;
          else if (ts_inc < LEARN_TS) ns = S_LERN;
          else                        ns = S_LRST;
        end
      end
      S_INFR: begin
        if (!req && all_inh) begin
          ts_nxt = ts_inc;
          if (ts_inc < LEARN_TS) rearm = 1'b1;
          else                   ns = S_IRST;
        end
      end
      S_IRST: begin
        if (!req && all_inh) begin
          ts_nxt = ts_inc;
          if (ts_inc == TOTAL_TS) ns = S_DONE;
          else                    rearm = 1'b1;
        end
      end
      S_DONE: begin
        ts_nxt = '0;
        ns     = S_IDLE;
      end
      default: ns = S_IDLE;
    endcase
    // Abort overrides the whole decision above, including any ts update
    if (i_abort && (cs != S_IDLE) && (cs != S_DONE)) begin
      ns          = S_DONE;
      ts_nxt      = ts;
      aborted_nxt = 1'b1;
      rearm       = 1'b0;
    end
    req_nxt = rearm || ((ns != cs) && (ns != S_IDLE) && (ns != S_DONE));
  end

  // Registered-only outputs: start pulses, status, decay strobe
  always_comb begin
    busy        = (cs != S_IDLE) && (cs != S_DONE);
    o_init      = req && (cs == S_INIT);
    o_run       = req && ((cs == S_LERN) || (cs == S_INFR));
    o_rest_run  = req && ((cs == S_LRST) || (cs == S_IRST));
    o_stdp_run  = req && (cs == S_STDP);
    o_busy      = busy;
    o_cnt_en    = busy;
    o_cnt_clr   = (cs == S_IDLE);
    o_done      = (cs == S_DONE);
    o_aborted   = aborted_q;
    o_state     = cs;
    o_time_step = ts;
    o_sub       = ((cs == S_LERN) || (cs == S_LRST) || (cs == S_STDP)) &&
                  (ts[SUB_LOG2-1:0] == '1);
  end

endmodule

// File: tb/tb_snn_phase_ctrl.sv
// tb_snn_phase_ctrl: bench for snn_phase_ctrl with small step counts.
// An engine model answers start pulses with completion flags; run
// outcomes are compared against a table and a per-run outcome model.
module tb_snn_phase_ctrl;

  localparam int NG = 8;
  localparam int TSW = 11;
  localparam int LS = 4;
  localparam int TS = 6;
  localparam int SL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_init = 1'b0, i_lern = 1'b0, i_infr = 1'b0, i_abort = 1'b0;
  logic [NG-1:0] i_grp_mask = '0, i_syn_done = '0, i_inh_valid = '0, i_stdp_done = '0;
  logic o_run, o_init, o_rest_run, o_stdp_run, o_cnt_en, o_cnt_clr, o_sub;
  logic o_busy, o_done, o_aborted;
  logic [2:0] o_state;
  logic [TSW-1:0] o_time_step;

  snn_phase_ctrl #(
    .N_GRP(NG), .TS_W(TSW), .LEARN_STEPS(LS), .TOTAL_STEPS(TS), .SUB_LOG2(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_init(i_init), .i_lern(i_lern), .i_infr(i_infr), .i_abort(i_abort),
    .i_grp_mask(i_grp_mask), .i_syn_done(i_syn_done),
    .i_inh_valid(i_inh_valid), .i_stdp_done(i_stdp_done),
    .o_run(o_run), .o_init(o_init), .o_rest_run(o_rest_run),
    .o_stdp_run(o_stdp_run), .o_cnt_en(o_cnt_en), .o_cnt_clr(o_cnt_clr),
    .o_sub(o_sub), .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted),
    .o_state(o_state), .o_time_step(o_time_step)
  );

  always #5 clk = ~clk;

  typedef struct {
    int init_p; int run_p; int rest_p; int stdp_p; int done_p; int sub_p; int ts_hi;
  } exp_t;

  typedef struct {
    logic [2:0] cmd;   // {init, lern, infr}
    logic [7:0] mask;
    exp_t       e;
    int         cyc;   // steps from command until o_done seen
  } vec_t;

  int n_cmp = 0, n_err = 0;
  int n_init, n_run, n_rest, n_stdp, n_done, n_sub, ts_max;
  bit sub_prev;
  bit eng_en = 1'b0, rand_mode = 1'b0;
  logic [7:0] cur_mask = '0;
  bit syn_set, inh_set, stdp_set;
  int syn_cnt, inh_cnt, stdp_cnt;
  int post_state, post_ts;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dly();
    if (rand_mode) return int'($urandom_range(1, 3));
    return 1;
  endfunction

  // Outcome of one accepted command, from the sequencing rules alone
  function automatic exp_t ref_model(input logic [2:0] cmd, input logic [7:0] mask);
    exp_t e = '{default: 0};
    if (cmd == 3'b000 || mask == 8'h00) return e;
    e.done_p = 1;
    if (cmd[2]) begin
      e.init_p = 1;
    end else begin
      e.run_p  = LS;
      e.rest_p = TS - LS;
      e.ts_hi  = TS;
      if (cmd[1]) begin
        e.stdp_p = TS;
        for (int k = 0; k < TS; k++)
          if (k % (1 << SL) == (1 << SL) - 1) e.sub_p++;
      end
    end
    return e;
  endfunction

  task automatic clear_counts();
    n_init = 0; n_run = 0; n_rest = 0; n_stdp = 0; n_done = 0; n_sub = 0;
    ts_max = 0; sub_prev = 1'b0;
  endtask

  task automatic eng_reset();
    syn_set = 0; inh_set = 0; stdp_set = 0;
    syn_cnt = 0; inh_cnt = 0; stdp_cnt = 0;
    i_syn_done = '0; i_inh_valid = '0; i_stdp_done = '0;
  endtask

  // One cycle: observe outputs at the falling edge, then let the engine answer
  task automatic step();
    logic [7:0] g;
    @(negedge clk);
    if (o_init)     n_init++;
    if (o_run)      n_run++;
    if (o_rest_run) n_rest++;
    if (o_stdp_run) n_stdp++;
    if (o_done)     n_done++;
    if (o_sub && !sub_prev) n_sub++;
    sub_prev = o_sub;
    if (int'(o_time_step) > ts_max) ts_max = int'(o_time_step);
    if (eng_en) begin
      if (o_init) begin syn_set = 0; syn_cnt = dly(); end
      else if (syn_cnt > 0) begin syn_cnt--; if (syn_cnt == 0) syn_set = 1; end
      if (o_run || o_rest_run) begin inh_set = 0; inh_cnt = dly(); end
      else if (inh_cnt > 0) begin inh_cnt--; if (inh_cnt == 0) inh_set = 1; end
      if (o_stdp_run) begin stdp_set = 0; stdp_cnt = dly(); end
      else if (stdp_cnt > 0) begin stdp_cnt--; if (stdp_cnt == 0) stdp_set = 1; end
      g = rand_mode ? 8'($urandom) : 8'h00;
      i_syn_done  = (syn_set  ? cur_mask : 8'h00) | (g & ~cur_mask);
      g = rand_mode ? 8'($urandom) : 8'h00;
      i_inh_valid = (inh_set  ? cur_mask : 8'h00) | (g & ~cur_mask);
      g = rand_mode ? 8'($urandom) : 8'h00;
      i_stdp_done = (stdp_set ? cur_mask : 8'h00) | (g & ~cur_mask);
    end
  endtask

  task automatic run_cmd(input logic [2:0] cmd, input logic [7:0] mask, input bit rnd,
                         output int cyc);
    clear_counts();
    cur_mask = mask; rand_mode = rnd; eng_en = 1'b1; cyc = 0;
    {i_init, i_lern, i_infr} = cmd;
    i_grp_mask = mask;
    for (int c = 1; c <= 400; c++) begin
      step();
      i_grp_mask = rnd ? 8'($urandom) : ~mask;
      if (rnd && o_busy) {i_init, i_lern, i_infr} = 3'($urandom);
      else               {i_init, i_lern, i_infr} = 3'b000;
      if (o_done) begin cyc = c; break; end
      if ((cmd == 3'b000 || mask == 8'h00) && c == 6) break;
    end
    step();
    post_state = int'(o_state);
    post_ts    = int'(o_time_step);
  endtask

  task automatic check_run(input string tag, input exp_t e);
    check({tag, ".init"}, n_init, e.init_p);
    check({tag, ".run"},  n_run,  e.run_p);
    check({tag, ".rest"}, n_rest, e.rest_p);
    check({tag, ".stdp"}, n_stdp, e.stdp_p);
    check({tag, ".done"}, n_done, e.done_p);
    check({tag, ".sub"},  n_sub,  e.sub_p);
    check({tag, ".tsmax"}, ts_max, e.ts_hi);
    check({tag, ".post_state"}, post_state, 0);
    check({tag, ".post_ts"}, post_ts, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[8];
    int cyc;
    bit hit;
    logic [2:0] rc;
    logic [7:0] rm;

    tbl[0] = '{3'b100, 8'hFF, '{1, 0, 0, 0, 1, 0, 0}, 3};
    tbl[1] = '{3'b010, 8'hFF, '{0, 4, 2, 6, 1, 1, 6}, 25};
    tbl[2] = '{3'b001, 8'hFF, '{0, 4, 2, 0, 1, 0, 6}, 13};
    tbl[3] = '{3'b010, 8'h0F, '{0, 4, 2, 6, 1, 1, 6}, 25};
    tbl[4] = '{3'b001, 8'h0F, '{0, 4, 2, 0, 1, 0, 6}, 13};
    tbl[5] = '{3'b010, 8'h00, '{0, 0, 0, 0, 0, 0, 0}, 0};
    tbl[6] = '{3'b011, 8'h3C, '{0, 4, 2, 6, 1, 1, 6}, 25};
    tbl[7] = '{3'b101, 8'h01, '{1, 0, 0, 0, 1, 0, 0}, 3};

    eng_reset();
    clear_counts();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst.state", o_state, 0);
    check("rst.cnt_clr", o_cnt_clr, 1);
    check("rst.ts", o_time_step, 0);
    check("rst.others", {o_run, o_init, o_rest_run, o_stdp_run, o_done,
                         o_aborted, o_sub, o_busy, o_cnt_en}, 0);
    rst_n = 1'b1;
    step();

    // Abort while idle is ignored
    i_abort = 1'b1; step(); i_abort = 1'b0;
    check("idle_abort.state", o_state, 0);
    check("idle_abort.aborted", o_aborted, 0);

    // Init waits for every participating group
    clear_counts(); eng_en = 1'b0;
    i_init = 1'b1; i_grp_mask = 8'hFF; step(); i_init = 1'b0;
    check("init.state", o_state, 1);
    check("init.pulse", o_init, 1);
    i_syn_done = 8'h7F;
    repeat (5) step();
    check("init.hold_state", o_state, 1);
    i_syn_done = 8'hFF; step();
    check("init.done_state", o_state, 7);
    check("init.done", o_done, 1);
    check("init.busy_in_done", o_busy, 0);
    step();
    check("init.idle", o_state, 0);
    check("init.n_init", n_init, 1);
    check("init.n_done", n_done, 1);
    eng_reset();

    // Table of full runs with the minimum-latency engine
    for (int i = 0; i < 8; i++) begin
      run_cmd(tbl[i].cmd, tbl[i].mask, 1'b0, cyc);
      check_run($sformatf("tbl%0d", i), tbl[i].e);
      check($sformatf("tbl%0d.cyc", i), cyc, tbl[i].cyc);
    end

    // Abort during learning step 2
    clear_counts(); eng_en = 1'b1; rand_mode = 1'b0; cur_mask = 8'hFF;
    i_lern = 1'b1; i_grp_mask = 8'hFF; step(); i_lern = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (o_time_step == 11'd2) begin hit = 1'b1; break; end
      step();
    end
    check("abort.reach_step2", hit, 1);
    i_abort = 1'b1; step(); i_abort = 1'b0;
    check("abort.state", o_state, 7);
    check("abort.done", o_done, 1);
    check("abort.aborted", o_aborted, 1);
    check("abort.ts_held", o_time_step, 2);
    step();
    check("abort.idle", o_state, 0);
    check("abort.ts_clear", o_time_step, 0);
    repeat (3) step();
    check("abort.sticky", o_aborted, 1);
    clear_counts();
    i_infr = 1'b1; i_grp_mask = 8'hFF; step(); i_infr = 1'b0;
    check("abort.infr_state", o_state, 4);
    check("abort.cleared", o_aborted, 0);
    check("abort.infr_pulse", o_run, 1);
    for (int c = 0; c < 200; c++) begin
      step();
      if (o_done) break;
    end
    step();
    check("abort.infr_runs", n_run, LS);
    check("abort.infr_done", n_done, 1);

    // Randomised runs: delays, garbage on masked-out groups, ignored commands
    for (int r = 0; r < 30; r++) begin
      rc = 3'($urandom_range(1, 7));
      rm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_cmd(rc, rm, 1'b1, cyc);
      check_run($sformatf("rnd%0d", r), ref_model(rc, rm));
    end
    rand_mode = 1'b0;

    // Reset in the middle of STDP, then simultaneous init + lern
    clear_counts(); cur_mask = 8'hFF;
    i_lern = 1'b1; i_grp_mask = 8'hFF; step(); i_lern = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (o_state == 3'd6) begin hit = 1'b1; break; end
      step();
    end
    check("rstmid.reach_stdp", hit, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid.state", o_state, 0);
    check("rstmid.ts", o_time_step, 0);
    check("rstmid.cnt_clr", o_cnt_clr, 1);
    check("rstmid.others", {o_run, o_init, o_rest_run, o_stdp_run, o_done,
                            o_aborted, o_sub, o_busy, o_cnt_en}, 0);
    @(negedge clk);
    eng_reset();
    rst_n = 1'b1;
    clear_counts();
    i_init = 1'b1; i_lern = 1'b1; i_grp_mask = 8'hFF; step();
    i_init = 1'b0; i_lern = 1'b0;
    check("prio.state", o_state, 1);
    check("prio.init_pulse", o_init, 1);
    for (int c = 0; c < 50; c++) begin
      step();
      if (o_done) break;
    end
    step();
    check("prio.n_done", n_done, 1);
    check("prio.n_run", n_run, 0);
    check("prio.idle", o_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snn_phase_ctrl.md
# snn_phase_ctrl

Parametrised top-level phase controller for the spiking-network core. It sequences synapse initialisation, learning (LERN/STDP with a rest tail) and inference (INFR with a rest tail) across `N_GRP` neuron groups. It waits on per-group completion flags, which a runtime mask can exclude. It also adds programmable step counts, abort, a done/aborted status and an exported time-step counter, and sits between the host command interface and the neuron/STDP/synapse engines.

## Interface
- `N_GRP`, 8, number of neuron groups
- `TS_W`, 11, time-step counter width
- `LEARN_STEPS`, 800, active steps before rest tail (learning and inference)
- `TOTAL_STEPS`, 1300, total steps per run; requires `0 < LEARN_STEPS < TOTAL_STEPS <= 2^TS_W-1`
- `SUB_LOG2`, 7, `o_sub` period is 2^SUB_LOG2 steps
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `i_init`, `i_lern`, `i_infr` in 1: commands, sampled only in IDLE; priority init > lern > infr
- `i_abort` in 1: abort current run
- `i_grp_mask` in N_GRP: 1 = group participates; latched when a command is accepted
- `i_syn_done`, `i_inh_valid`, `i_stdp_done` in N_GRP: per-group level flags
- `o_run`, `o_init`, `o_rest_run`, `o_stdp_run` out 1: one-cycle start pulses to the engines
- `o_cnt_en`, `o_cnt_clr` out 1: spike-counter enable/clear
- `o_sub` out 1: weight-decay strobe
- `o_busy`, `o_done`, `o_aborted` out 1: status
- `o_state` out 3: current state encoding
- `o_time_step` out TS_W: current step

## Operation
- States (encoding): IDLE 0, INIT 1, LERN 2, LRST 3, INFR 4, IRST 5, STDP 6, DONE 7.
- `all_X = &(i_X | ~mask_q)` over the latched mask.
- A command with `i_grp_mask == 0` is ignored; the block stays in IDLE.
- Internal `req` flag: set on entry to INIT/LERN/LRST/INFR/IRST/STDP and on each step completion that stays in INFR/IRST; it is cleared the following cycle.
- While `req` is high:
  - `o_init` is high in INIT.
  - `o_run` is high in LERN or INFR.
  - `o_rest_run` is high in LRST or IRST.
  - `o_stdp_run` is high in STDP.
- Completion flags are ignored in a cycle where `req` is high, so stale valids are never consumed.
- IDLE:
  - `i_init` → INIT, `i_lern` → LERN, `i_infr` → INFR.
  - Accepting a command latches the mask, clears `ts` and clears `o_aborted`.
- INIT: `all_syn_done` → DONE.
- LERN/LRST: `all_inh_valid` → STDP.
- STDP, on `all_stdp_done`, let `n = ts+1` and `ts <= n`:
  - `n == TOTAL_STEPS` → DONE.
  - else `n < LEARN_STEPS` → LERN.
  - else → LRST.
- INFR, on `all_inh_valid`, `ts <= ts+1`:
  - `ts+1 < LEARN_STEPS` → stay in INFR, re-arm `req`.
  - else → IRST.
- IRST, on `all_inh_valid`, `ts <= ts+1`:
  - `ts+1 == TOTAL_STEPS` → DONE.
  - else stay in IRST, re-arm `req`.
- DONE: one cycle, `o_done = 1`, `ts <= 0` → IDLE.
- Abort: `i_abort` in any state other than IDLE/DONE forces DONE next cycle, overriding every other transition and any `ts` update. It sets `o_aborted`, which is sticky until the next accepted command. `i_abort` in IDLE/DONE has no effect.
- `ts` never wraps; the STDP/IRST checks terminate the run at `TOTAL_STEPS`.
- `o_sub = (ts[SUB_LOG2-1:0] == all ones)` while in LERN, LRST or STDP; 0 otherwise.
- `o_cnt_en = o_busy = !(IDLE || DONE)`; `o_cnt_clr = IDLE`; `o_time_step = ts`; `o_state = cs`.

## Timing
- Reset values: `cs = IDLE`, `ts = 0`, `req = 0`, `mask_q = 0`, `o_aborted = 0`.
- Outputs at reset: all 0 except `o_cnt_clr = 1`, `o_state = 0`.
- All outputs are combinational from registers only; there is no input-to-output combinational path.
- Command sampled at edge k → new state from cycle k+1, start pulse in cycle k+1.
- Learning step, minimum 4 cycles:
  - `o_run` at t.
  - `all_inh` sampled at t+1 → `o_stdp_run` at t+2.
  - `all_stdp` at t+3 → `o_run` at t+4.
- Inference step minimum 2 cycles: pulse at t, next pulse at t+2.
- Reset mid-run: immediate return to IDLE with reset values; no `o_done`.
- Simultaneous command inputs: priority order as listed; lower-priority commands are dropped, not queued.

## Test plan
- Reset, then `i_init` with mask `8'hFF`; raise `i_syn_done` on groups 0–6 only → stays INIT; raise group 7 → DONE for 1 cycle (`o_done = 1`), then IDLE. Exactly one `o_init` pulse.
- `LEARN_STEPS = 4`, `TOTAL_STEPS = 6`, `i_lern`, engine model returns flags 1 cycle after each pulse → 4 `o_run`, 2 `o_rest_run`, 6 `o_stdp_run`; `o_time_step` reaches 6, then 0 in DONE.
- Same parameters, `i_infr` → 4 `o_run`, 2 `o_rest_run`, 0 `o_stdp_run`; one `o_done`.
- Mask `8'h0F`, groups 4–7 flags held at 0 → run completes normally; mask `8'h00` with `i_lern` → remains IDLE, no pulses.
- `i_abort` at step 2 of learning → DONE next cycle, `o_aborted = 1` until the next `i_infr` is accepted, then 0; `ts` cleared.
- Assert `rst_n = 0` mid-STDP → outputs at reset values immediately; `i_init` and `i_lern` in the same cycle → INIT chosen.
